// File: rtl/vr16_pkg.sv
// Shared definitions for the vr16 datapath: widths, opcodes, register indices
// and the execute-stage state encoding.
package vr16_pkg;

    localparam int DATA_W     = 16;
    localparam int MUL_CYCLES = 16;

    localparam logic [3:0] OP_ADD       = 4'd0;
    localparam logic [3:0] OP_SUB       = 4'd1;
    localparam logic [3:0] OP_AND       = 4'd2;
    localparam logic [3:0] OP_OR        = 4'd3;
    localparam logic [3:0] OP_XOR       = 4'd4;
    localparam logic [3:0] OP_NOT       = 4'd5;
    localparam logic [3:0] OP_SHL       = 4'd6;
    localparam logic [3:0] OP_SHR       = 4'd7;
    localparam logic [3:0] OP_MUL       = 4'd8;
    localparam logic [3:0] OP_MOV       = 4'd9;
    localparam logic [3:0] OP_NOP_FIRST = 4'd10;
    localparam logic [3:0] OP_NOP_LAST  = 4'd15;

    localparam logic [1:0] REG_A = 2'b00;
    localparam logic [1:0] REG_B = 2'b01;
    localparam logic [1:0] REG_C = 2'b10;
    localparam logic [1:0] REG_D = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier retiring one multiplier bit per clock. o_done and
// o_product describe the step being taken at the coming edge, so the caller
// can capture the finished product on the same edge the last step completes.
module seq_multiplier
    import vr16_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_op_a,
    input  logic [DATA_W-1:0]     i_op_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic                r_busy;
    logic [CNT_W-1:0]    r_count;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic                w_last;
    logic [2*DATA_W-1:0] w_next_acc;

    assign w_last     = r_busy && (r_count == CNT_W'(MUL_CYCLES - 1));
    assign w_next_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_product = w_next_acc;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start && !r_busy) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, i_op_a};
            r_mplier <= i_op_b;
        end else if (r_busy) begin
            r_acc    <= w_next_acc;
            r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage in front of the 4x16 register file. Forwards the
// pending writeback into both operands, runs single-cycle ALU ops directly and
// hands MUL to the sequential multiplier while holding off new issues.
module exec_stage
    import vr16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        opcode,
    input  logic [1:0]        dest,
    input  logic [1:0]        src1,
    input  logic [1:0]        src2,
    output logic [1:0]        read_operand_one_reg,
    output logic [1:0]        read_operand_two_reg,
    input  logic [DATA_W-1:0] operand_one_reg,
    input  logic [DATA_W-1:0] operand_two_reg,
    output logic              write_enable,
    output logic [1:0]        store_at,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              busy
);

    exec_state_t           r_state;
    exec_state_t           w_next_state;
    logic                  r_we;
    logic [1:0]            r_store;
    logic [DATA_W-1:0]     r_result;
    logic                  r_zero;
    logic                  r_carry;
    logic [1:0]            r_mul_dest;

    logic                  w_accept;
    logic                  w_mul_start;
    logic                  w_mul_done;
    logic                  w_mul_busy;
    logic [2*DATA_W-1:0]   w_mul_product;
    logic [DATA_W-1:0]     w_op1;
    logic [DATA_W-1:0]     w_op2;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W-1:0]     w_alu_res;
    logic                  w_alu_carry;
    logic                  w_alu_wb;

    assign read_operand_one_reg = src1;
    assign read_operand_two_reg = src2;

    assign issue_ready = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_MUL);
    assign w_accept    = issue_valid && issue_ready;
    assign w_mul_start = w_accept && (opcode == OP_MUL);

    // The register file only commits a write at the end of the strobe cycle,
    // so a source matching the pending destination must take alu_result
    assign w_op1 = (r_we && (r_store == src1)) ? r_result : operand_one_reg;
    assign w_op2 = (r_we && (r_store == src2)) ? r_result : operand_two_reg;

    assign w_sum  = {1'b0, w_op1} + {1'b0, w_op2};
    assign w_diff = {1'b0, w_op1} - {1'b0, w_op2};

    assign write_enable = r_we;
    assign store_at     = r_store;
    assign alu_result   = r_result;
    assign zero_flag    = r_zero;
    assign carry_flag   = r_carry;

    seq_multiplier u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_op_a    (w_op1),
        .i_op_b    (w_op2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Single-cycle ALU result and carry; MUL and NOPs produce no direct writeback
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_wb    = 1'b1;
        case (opcode)
            OP_ADD: begin w_alu_res = w_sum[DATA_W-1:0];  w_alu_carry = w_sum[DATA_W];  end
            OP_SUB: begin w_alu_res = w_diff[DATA_W-1:0]; w_alu_carry = w_diff[DATA_W]; end
            OP_AND: w_alu_res = w_op1 & w_op2;
            OP_OR:  w_alu_res = w_op1 | w_op2;
            OP_XOR: w_alu_res = w_op1 ^ w_op2;
            OP_NOT: w_alu_res = ~w_op1;
            OP_SHL: begin w_alu_res = {w_op1[DATA_W-2:0], 1'b0}; w_alu_carry = w_op1[DATA_W-1]; end
            OP_SHR: begin w_alu_res = {1'b0, w_op1[DATA_W-1:1]}; w_alu_carry = w_op1[0]; end
            OP_MOV: w_alu_res = w_op1;
            default: w_alu_wb = 1'b0;
        endcase
    end

    // Next-state: leave IDLE on an accepted MUL, return when the last multiply step retires
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_next_state = ST_MUL;
            ST_MUL:  if (w_mul_done && w_mul_busy) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Writeback registers: strobe for one cycle per result, otherwise hold data and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_store    <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_mul_dest <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_state == ST_MUL && w_mul_done) begin
                r_we     <= 1'b1;
                r_store  <= r_mul_dest;
                r_result <= w_mul_product[DATA_W-1:0];
                r_zero   <= (w_mul_product[DATA_W-1:0] == '0);
                r_carry  <= |w_mul_product[2*DATA_W-1:DATA_W];
            end else if (w_mul_start) begin
                r_mul_dest <= dest;
            end else if (w_accept && w_alu_wb) begin
                r_we     <= 1'b1;
                r_store  <= dest;
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_carry  <= w_alu_carry;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage. A bench-side register file feeds the
// operand ports and commits writebacks; an architectural model predicts every
// writeback in program order into a scoreboard checked by a monitor.
module tb_exec_stage;
    import vr16_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  opcode;
    logic [1:0]  dest, src1, src2;
    logic [1:0]  read_operand_one_reg, read_operand_two_reg;
    logic [15:0] operand_one_reg, operand_two_reg;
    logic        write_enable;
    logic [1:0]  store_at;
    logic [15:0] alu_result;
    logic        zero_flag, carry_flag, busy;

    typedef struct packed {
        logic [1:0]  store;
        logic [15:0] res;
        logic        z;
        logic        c;
    } wb_t;

    wb_t         sbQ[$];
    wb_t         monExp;
    wb_t         lastWb;
    logic [15:0] rf[4];
    logic [15:0] mreg[4];
    logic        pokeEn;
    logic [1:0]  pokeIdx;
    logic [15:0] pokeVal;
    int          checks = 0;
    int          errors = 0;

    exec_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .issue_valid          (issue_valid),
        .issue_ready          (issue_ready),
        .opcode               (opcode),
        .dest                 (dest),
        .src1                 (src1),
        .src2                 (src2),
        .read_operand_one_reg (read_operand_one_reg),
        .read_operand_two_reg (read_operand_two_reg),
        .operand_one_reg      (operand_one_reg),
        .operand_two_reg      (operand_two_reg),
        .write_enable         (write_enable),
        .store_at             (store_at),
        .alu_result           (alu_result),
        .zero_flag            (zero_flag),
        .carry_flag           (carry_flag),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    assign operand_one_reg = rf[read_operand_one_reg];
    assign operand_two_reg = rf[read_operand_two_reg];

    // Register file: commits the strobed writeback at the end of its cycle
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (pokeEn) begin
            rf[pokeIdx] <= pokeVal;
        end else if (write_enable) begin
            rf[store_at] <= alu_result;
        end
    end

    // Monitor: every strobe must match the oldest predicted writeback
    always @(negedge clk) begin
        if (!reset && write_enable) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_wb got store=%0d res=%h z=%b c=%b, expected no writeback",
                         store_at, alu_result, zero_flag, carry_flag);
            end else begin
                monExp = sbQ.pop_front();
                if ({store_at, alu_result, zero_flag, carry_flag} !== monExp) begin
                    errors++;
                    $display("[TB] FAIL wb_data got store=%0d res=%h z=%b c=%b, expected store=%0d res=%h z=%b c=%b",
                             store_at, alu_result, zero_flag, carry_flag,
                             monExp.store, monExp.res, monExp.z, monExp.c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic wb);
        logic [16:0] s;
        logic [31:0] p;
        r = '0; c = 1'b0; wb = 1'b1;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = a << 1; c = a[15]; end
            4'd7: begin r = a >> 1; c = a[0]; end
            4'd8: begin p = 32'(a) * 32'(b); r = p[15:0]; c = (p[31:16] != 16'h0); end
            4'd9: r = a;
            default: wb = 1'b0;
        endcase
    endfunction

    task automatic setReg(input logic [1:0] idx, input logic [15:0] val);
        pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
        mreg[idx] = val;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    // Present one instruction, hold it until accepted, and predict its writeback
    task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s1,
                         input logic [1:0] s2, input bit track, output int waited);
        logic [15:0] r;
        logic        c, wb;
        opcode = op; dest = d; src1 = s1; src2 = s2; issue_valid = 1'b1;
        waited = 0;
        while (issue_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout op=%0d issue_ready=%b, expected 1 within 100 cycles", op, issue_ready);
            issue_valid = 1'b0;
            return;
        end
        if (track) begin
            model(op, mreg[s1], mreg[s2], r, c, wb);
            if (wb) begin
                sbQ.push_back('{d, r, (r == 16'h0), c});
                lastWb = '{d, r, (r == 16'h0), c};
                mreg[d] = r;
            end
        end
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue_valid = 1'b0; opcode = '0; dest = '0; src1 = 2'd2; src2 = 2'd3;
        pokeEn = 1'b0; pokeIdx = '0; pokeVal = '0;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        lastWb = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({write_enable, store_at, alu_result, zero_flag, carry_flag, busy, issue_ready} !== {1'b0, 2'b0, 16'h0, 3'b001}) begin
            errors++;
            $display("[TB] FAIL reset_outputs got we=%b st=%0d res=%h z=%b c=%b busy=%b rdy=%b, expected 0/0/0000/0/0/0/1",
                     write_enable, store_at, alu_result, zero_flag, carry_flag, busy, issue_ready);
        end
        checks++;
        if ({read_operand_one_reg, read_operand_two_reg} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL read_selects got %0d/%0d, expected 2/3", read_operand_one_reg, read_operand_two_reg);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int w;
        setReg(REG_B, 16'h0005);
        issue(OP_ADD, REG_A, REG_A, REG_B, 1'b1, w);
        checks++;
        if (write_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_strobe got we=%b, expected 1", write_enable);
        end
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_strobe_width got we=%b, expected 0", write_enable);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        setReg(REG_A, 16'h1234);
        issue(OP_MOV, REG_B, REG_A, REG_A, 1'b1, w);
        issue(OP_ADD, REG_C, REG_B, REG_B, 1'b1, w);
        drain();
        checks++;
        if (mreg[REG_C] !== 16'h2468) begin
            errors++;
            $display("[TB] FAIL b2b_model got %h, expected 2468", mreg[REG_C]);
        end
    endtask

    task automatic test_sub_carry();
        int w;
        setReg(REG_A, 16'h0003);
        setReg(REG_B, 16'h0005);
        issue(OP_SUB, REG_D, REG_A, REG_B, 1'b1, w);
        drain();
        setReg(REG_A, 16'hFFFF);
        setReg(REG_B, 16'h0001);
        issue(OP_ADD, REG_C, REG_A, REG_B, 1'b1, w);
        drain();
        checks++;
        if ({alu_result, zero_flag, carry_flag} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL add_wrap_hold got res=%h z=%b c=%b, expected 0000/1/1", alu_result, zero_flag, carry_flag);
        end
    endtask

    task automatic test_nop();
        int w;
        issue(4'd12, REG_A, REG_B, REG_C, 1'b1, w);
        checks++;
        if ({write_enable, store_at, alu_result, zero_flag, carry_flag} !== {1'b0, lastWb}) begin
            errors++;
            $display("[TB] FAIL nop_hold got we=%b st=%0d res=%h z=%b c=%b, expected we=0 st=%0d res=%h z=%b c=%b",
                     write_enable, store_at, alu_result, zero_flag, carry_flag,
                     lastWb.store, lastWb.res, lastWb.z, lastWb.c);
        end
        drain();
    endtask

    task automatic test_mul();
        int w, cnt;
        setReg(REG_A, 16'h0100);
        setReg(REG_B, 16'h0300);
        issue(OP_MUL, REG_D, REG_A, REG_B, 1'b1, w);
        cnt = 0;
        while (busy === 1'b1 && issue_ready === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("[TB] FAIL mul_busy_cycles got %0d, expected 16", cnt);
        end
        checks++;
        if ({write_enable, issue_ready, busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL mul_wb_timing got we=%b rdy=%b busy=%b, expected 1/1/0", write_enable, issue_ready, busy);
        end
        drain();
    endtask

    task automatic test_mul_queued();
        int w;
        setReg(REG_A, 16'h0007);
        setReg(REG_B, 16'h0006);
        issue(OP_MUL, REG_C, REG_A, REG_B, 1'b1, w);
        issue(OP_ADD, REG_D, REG_C, REG_A, 1'b1, w);
        checks++;
        if (w != 16) begin
            errors++;
            $display("[TB] FAIL mul_queued_wait got %0d, expected 16", w);
        end
        drain();
        checks++;
        if (mreg[REG_D] !== 16'h0031) begin
            errors++;
            $display("[TB] FAIL mul_queued_model got %h, expected 0031", mreg[REG_D]);
        end
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 4; i++) setReg(2'(i), 16'($urandom));
        for (int i = 0; i < 30; i++) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom), 1'b1, w);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        int w, pulses;
        setReg(REG_A, 16'h0100);
        setReg(REG_B, 16'h0003);
        issue(OP_MUL, REG_D, REG_A, REG_B, 1'b0, w);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        #1;
        checks++;
        if ({write_enable, store_at, alu_result, zero_flag, carry_flag, busy, issue_ready} !== {1'b0, 2'b0, 16'h0, 3'b001}) begin
            errors++;
            $display("[TB] FAIL mid_mul_reset got we=%b st=%0d res=%h z=%b c=%b busy=%b rdy=%b, expected 0/0/0000/0/0/0/1",
                     write_enable, store_at, alu_result, zero_flag, carry_flag, busy, issue_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (write_enable === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || issue_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_mul_abort got pulses=%0d rdy=%b, expected 0/1", pulses, issue_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_sub_carry();
        test_nop();
        test_mul();
        test_mul_queued();
        test_random();
        test_reset_mid_mul();
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_empty got %0d pending writebacks, expected 0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute/writeback stage directly upstream of the 4x16-bit general-purpose register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file's two operand read selects.
- Computes single-cycle ALU ops, or a 16-cycle shift-add multiply.
- Drives write_enable / store_at / alu_result into the register file, with one-deep forwarding of the pending writeback.

Parameters:
- DATA_W, 16, datapath width; matches register file width.
- MUL_CYCLES, 16, iterations of the shift-add multiplier; equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decoder presents an instruction.
- issue_ready  output  1  stage can accept this cycle.
- opcode  input  4  operation code.
- dest  input  2  destination register index (00=A, 01=B, 10=C, 11=D).
- src1  input  2  operand-one register index.
- src2  input  2  operand-two register index.
- read_operand_one_reg  output  2  to register file; combinational copy of src1.
- read_operand_two_reg  output  2  to register file; combinational copy of src2.
- operand_one_reg  input  16  register file read data, port one.
- operand_two_reg  input  16  register file read data, port two.
- write_enable  output  1  one-cycle writeback strobe.
- store_at  output  2  writeback register index.
- alu_result  output  16  writeback data.
- zero_flag  output  1  last writeback result == 0.
- carry_flag  output  1  carry/borrow/shift-out/overflow of last writeback.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (async): state IDLE; issue_ready=1; write_enable=0; store_at=0; alu_result=0; zero_flag=0; carry_flag=0; busy=0; multiplier accumulator, counter and latched operands cleared.
- Reset mid-multiply: operation aborted, no writeback.
- States: IDLE, MUL.
  - issue_ready=1 in IDLE, 0 in MUL.
  - busy = (state==MUL).
- Accept = issue_valid & issue_ready at a rising edge. Operands are sampled that same edge.
- Forwarding:
  - effective op1 = (write_enable && store_at==src1) ? alu_result : operand_one_reg.
  - op2 uses src2 the same way.
  - Reason: the register file has not yet committed the pending write.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT op1, 6 SHL op1 by 1, 7 SHR (logical) op1 by 1, 8 MUL, 9 MOV op1, 10-15 NOP.
- Width rules: all results truncated to 16 bits.
  - ADD carry = bit 16 of the 17-bit sum.
  - SUB carry = borrow (op1 < op2 unsigned).
  - SHL carry = op1[15]; SHR carry = op1[0].
  - Logic ops and MOV carry = 0.
  - MUL carry = 1 iff the upper 16 bits of the 32-bit product are nonzero.
- Single-cycle op accepted at edge N:
  - write_enable=1 for exactly the cycle after edge N.
  - store_at=dest, alu_result=result, flags updated at edge N.
  - Back-to-back accepts allowed every cycle.
- NOP accepted: write_enable=0 next cycle; flags and alu_result hold.
- No accept: write_enable=0 next cycle; alu_result and store_at hold their last value.
- MUL accepted at edge N:
  - Enter MUL; latch forwarded operands; counter=0.
  - Each following edge performs one shift-add step.
  - After MUL_CYCLES steps (edge N+16): return to IDLE, write_enable=1 for the cycle after edge N+16 with product[15:0], flags updated.
  - issue_ready returns to 1 in that same cycle, so the next instruction can forward the MUL result.
- Writeback pending when MUL is accepted: that writeback's strobe still occurs normally in the next cycle; MUL operands have already been forwarded.
- Simultaneous events: accepting a new op while write_enable is high is legal; the new result replaces the strobe contents on the next cycle.
- Flags update only on writebacks.

Decomposition:
- Shared package vr16_pkg:
  - Opcode localparams (OP_ADD..OP_MOV, OP_NOP range).
  - Register index constants REG_A..REG_D.
  - DATA_W.
- Sub-module seq_multiplier: start/done handshake, 16-bit x 16-bit -> 32-bit shift-add, one bit per cycle, async reset.
- exec_stage contains the FSM, forwarding muxes, single-cycle ALU and writeback registers.

Test Plan:
- Reset with A..D=0, then ADD A<=A+B with B preloaded 0x0005 by MOV chain -> write_enable one cycle, store_at=00, alu_result=0x0005, zero=0, carry=0.
- Back-to-back MOV B<=A (A=0x1234) then ADD C<=B+B next cycle -> second op uses forwarded 0x1234; alu_result=0x2468, store_at=10.
- SUB with A=0x0003, B=0x0005 -> alu_result=0xFFFE, carry=1. ADD 0xFFFF+0x0001 -> alu_result=0x0000, zero=1, carry=1.
- MUL D<=A*B with A=0x0100, B=0x0300 -> issue_ready=0 and busy=1 for 16 cycles; write_enable 17 cycles after accept; alu_result=0x0000, carry=1 (product 0x30000), zero=1.
- MUL 0x0007*0x0006 with issue_valid held high and an ADD queued -> ADD is not accepted until the writeback cycle; the ADD then forwards 0x002A.
- Assert reset at cycle 8 of a MUL -> no write_enable ever pulses; all outputs at reset values; issue_ready=1 after reset deasserts.
